// File: rtl/bp_clint_initiator_pkg.sv
// BedRock message types, proc-param widths and CLINT constants for the CLINT initiator.
package bp_clint_initiator_pkg;

    typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

    function automatic int unsigned bp_paddr_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 32'd40;
            default:          return 32'd40;
        endcase
    endfunction

    function automatic int unsigned bp_lce_id_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 32'd4;
            default:          return 32'd4;
        endcase
    endfunction

    localparam int unsigned dword_width_gp       = 64;
    localparam int unsigned bp_paddr_width_gp    = bp_paddr_width_f(e_bp_default_cfg);
    localparam int unsigned bp_lce_id_width_gp   = bp_lce_id_width_f(e_bp_default_cfg);
    localparam int unsigned clint_timeout_cycles_gp = 1024;

    localparam logic [bp_paddr_width_gp-1:0] mtimecmp_reg_base_addr_gp = 40'h00_0030_4000;
    localparam logic [bp_paddr_width_gp-1:0] mtime_reg_addr_gp         = 40'h00_0030_bff8;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'b0000,
        e_bedrock_mem_wr    = 4'b0001,
        e_bedrock_mem_uc_rd = 4'b0010,
        e_bedrock_mem_uc_wr = 4'b0011,
        e_bedrock_mem_pre   = 4'b0100,
        e_bedrock_mem_amo   = 4'b0101
    } bp_bedrock_mem_type_e;

    typedef enum logic [3:0] {
        e_bedrock_store   = 4'b0000,
        e_bedrock_amolr   = 4'b0001,
        e_bedrock_amosc   = 4'b0010,
        e_bedrock_amoswap = 4'b0011,
        e_bedrock_amoadd  = 4'b0100
    } bp_bedrock_wr_subop_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'b000,
        e_bedrock_msg_size_2   = 3'b001,
        e_bedrock_msg_size_4   = 3'b010,
        e_bedrock_msg_size_8   = 3'b011,
        e_bedrock_msg_size_16  = 3'b100,
        e_bedrock_msg_size_32  = 3'b101,
        e_bedrock_msg_size_64  = 3'b110,
        e_bedrock_msg_size_128 = 3'b111
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [bp_lce_id_width_gp-1:0] lce_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s        payload;
        bp_bedrock_msg_size_e           size;
        logic [bp_paddr_width_gp-1:0]   addr;
        bp_bedrock_wr_subop_e           subop;
        bp_bedrock_mem_type_e           msg_type;
    } bp_bedrock_mem_header_s;

    typedef struct packed {
        logic [dword_width_gp-1:0]  data;
        bp_bedrock_mem_header_s     header;
    } bp_bedrock_mem_msg_s;

endpackage

// File: rtl/bp_clint_initiator_timer.sv
// Clear/up response-wait timer that saturates at max_val_p.
module bp_clint_initiator_timer #(
    parameter int unsigned width_p   = 10,
    parameter int unsigned max_val_p = 1023
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    // Clear wins over increment; increment stops at the saturation value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i && (count_q != width_p'(max_val_p))) begin
            count_d = count_q + width_p'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_clint_initiator.sv
// Single-outstanding uncached BedRock initiator used to reach CLINT registers.
module bp_clint_initiator
    import bp_clint_initiator_pkg::*;
#(
    parameter bp_params_e  bp_params_p      = e_bp_default_cfg,
    parameter int unsigned timeout_cycles_p = clint_timeout_cycles_gp,
    localparam int unsigned paddr_width_p        = bp_paddr_width_f(bp_params_p),
    localparam int unsigned lce_id_width_p       = bp_lce_id_width_f(bp_params_p),
    localparam int unsigned msg_size_width_lp    = $bits(bp_bedrock_msg_size_e),
    localparam int unsigned xce_mem_msg_width_lp = $bits(bp_bedrock_mem_msg_s)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [lce_id_width_p-1:0]       lce_id_i,

    input  logic                            req_v_i,
    output logic                            req_ready_and_o,
    input  logic                            req_w_i,
    input  logic [paddr_width_p-1:0]        req_addr_i,
    input  logic [dword_width_gp-1:0]       req_data_i,
    input  logic [msg_size_width_lp-1:0]    req_size_i,

    output logic [xce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_and_i,

    input  logic [xce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o,

    output logic [dword_width_gp-1:0]       rdata_o,
    output logic                            rdata_err_o,
    output logic                            rdata_v_o,
    input  logic                            rdata_yumi_i,

    output logic                            busy_o
);

    localparam int unsigned timer_width_lp = (timeout_cycles_p <= 1) ? 1 : $clog2(timeout_cycles_p);

    typedef enum logic [2:0] {e_ready, e_send, e_wait, e_reply, e_drain} state_e;

    state_e                    state_q, state_d;
    bp_bedrock_mem_msg_s       cmd_q, cmd_d;
    bp_bedrock_mem_msg_s       resp_li;
    logic [dword_width_gp-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      drain_q, drain_d;
    logic                      init_q;
    logic [timer_width_lp-1:0] timer_lo;
    logic                      timer_expired;
    logic                      resp_unused;

    assign resp_li       = bp_bedrock_mem_msg_s'(mem_resp_i);
    assign resp_unused   = ^{resp_li.header.subop, resp_li.header.size, resp_li.header.payload};
    assign timer_expired = (timer_lo == timer_width_lp'(timeout_cycles_p - 1));

    // Wait timer: restarts when the command is taken, runs only while no response is seen.
    bp_clint_initiator_timer #(
        .width_p   (timer_width_lp),
        .max_val_p (timeout_cycles_p - 1)
    ) timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i ((state_q == e_send) && mem_cmd_ready_and_i),
        .up_i    ((state_q == e_wait) && !mem_resp_v_i),
        .count_o (timer_lo)
    );

    // Next-state and datapath capture; a response beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        drain_d = drain_q;
        unique case (state_q)
            e_ready: begin
                if (req_v_i && req_ready_and_o) begin
                    cmd_d                        = '0;
                    cmd_d.header.msg_type        = req_w_i ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
                    cmd_d.header.subop           = e_bedrock_store;
                    cmd_d.header.addr            = req_addr_i;
                    cmd_d.header.size            = bp_bedrock_msg_size_e'(req_size_i);
                    cmd_d.header.payload.lce_id  = lce_id_i;
                    cmd_d.data                   = req_w_i ? req_data_i : '0;
                    state_d                      = e_send;
                end
            end
            e_send: begin
                if (mem_cmd_ready_and_i) begin
                    state_d = e_wait;
                end
            end
            e_wait: begin
                if (mem_resp_v_i) begin
                    rdata_d = resp_li.data;
                    err_d   = (resp_li.header.msg_type != cmd_q.header.msg_type)
                            || (resp_li.header.addr != cmd_q.header.addr);
                    state_d = e_reply;
                end else if (timer_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = e_reply;
                end
            end
            e_reply: begin
                if (rdata_yumi_i) begin
                    state_d = drain_q ? e_drain : e_ready;
                end
            end
            e_drain: begin
                if (mem_resp_v_i) begin
                    drain_d = 1'b0;
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // State and datapath registers; init_q holds off ready until the first edge after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            drain_q <= drain_d;
            init_q  <= 1'b1;
        end
    end

    assign req_ready_and_o = init_q && (state_q == e_ready);
    assign mem_cmd_v_o     = (state_q == e_send);
    assign mem_cmd_o       = cmd_q;
    assign mem_resp_yumi_o = mem_resp_v_i && ((state_q == e_wait) || (state_q == e_drain));
    assign rdata_v_o       = (state_q == e_reply);
    assign rdata_o         = rdata_q;
    assign rdata_err_o     = err_q;
    assign busy_o          = (state_q != e_ready);

endmodule

// File: tb/tb_bp_clint_initiator.sv
// Directed scoreboard bench for bp_clint_initiator (timeout shortened to 16 cycles).
module tb_bp_clint_initiator;
    import bp_clint_initiator_pkg::*;

    localparam int unsigned timeout_lp = 16;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        int          lat;
    } exp_reply_t;

    logic                           clk;
    logic                           reset;
    logic [bp_lce_id_width_gp-1:0]  lce_id;
    logic                           req_v;
    logic                           req_ready;
    logic                           req_w;
    logic [bp_paddr_width_gp-1:0]   req_addr;
    logic [63:0]                    req_data;
    logic [2:0]                     req_size;
    bp_bedrock_mem_msg_s            mem_cmd;
    logic                           mem_cmd_v;
    logic                           mem_cmd_ready;
    bp_bedrock_mem_msg_s            mem_resp;
    logic                           mem_resp_v;
    logic                           mem_resp_yumi;
    logic [63:0]                    rdata;
    logic                           rdata_err;
    logic                           rdata_v;
    logic                           rdata_yumi;
    logic                           busy;

    int n_tests = 0;
    int n_fail  = 0;

    bp_bedrock_mem_msg_s exp_cmd_q[$];
    exp_reply_t          exp_rep_q[$];

    bp_clint_initiator #(
        .bp_params_p      (e_bp_default_cfg),
        .timeout_cycles_p (timeout_lp)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .lce_id_i            (lce_id),
        .req_v_i             (req_v),
        .req_ready_and_o     (req_ready),
        .req_w_i             (req_w),
        .req_addr_i          (req_addr),
        .req_data_i          (req_data),
        .req_size_i          (req_size),
        .mem_cmd_o           (mem_cmd),
        .mem_cmd_v_o         (mem_cmd_v),
        .mem_cmd_ready_and_i (mem_cmd_ready),
        .mem_resp_i          (mem_resp),
        .mem_resp_v_i        (mem_resp_v),
        .mem_resp_yumi_o     (mem_resp_yumi),
        .rdata_o             (rdata),
        .rdata_err_o         (rdata_err),
        .rdata_v_o           (rdata_v),
        .rdata_yumi_i        (rdata_yumi),
        .busy_o              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bp_bedrock_mem_msg_s mk_resp(input bp_bedrock_mem_type_e t,
                                                    input logic [bp_paddr_width_gp-1:0] a,
                                                    input logic [63:0] d);
        bp_bedrock_mem_msg_s m;
        m                 = '0;
        m.header.msg_type = t;
        m.header.subop    = e_bedrock_store;
        m.header.addr     = a;
        m.header.size     = e_bedrock_msg_size_8;
        m.data            = d;
        return m;
    endfunction

    // mode: 0 matching response, 1 address mismatch, 2 type mismatch, 3 no response (timeout)
    task automatic run_txn(input string tag, input logic w, input logic [bp_paddr_width_gp-1:0] addr,
                           input logic [63:0] data, input logic [3:0] lce, input int stall,
                           input int wait_n, input int mode, input logic [63:0] resp_data);
        bp_bedrock_mem_msg_s  ec;
        bp_bedrock_mem_msg_s  held;
        bp_bedrock_mem_type_e rt;
        logic [63:0]          rdata_seen;
        exp_reply_t           er;
        int                   lat;
        int                   guard;

        ec                            = '0;
        ec.header.msg_type            = w ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
        ec.header.subop               = e_bedrock_store;
        ec.header.addr                = addr;
        ec.header.size                = e_bedrock_msg_size_8;
        ec.header.payload.lce_id      = lce;
        ec.data                       = w ? data : 64'h0;
        exp_cmd_q.push_back(ec);
        er.data = (mode == 3) ? 64'h0 : resp_data;
        er.err  = (mode != 0);
        er.lat  = (mode == 3) ? (3 + int'(timeout_lp) + stall) : (4 + stall + wait_n);
        exp_rep_q.push_back(er);

        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " req_ready"}, req_ready, 1'b1);
        req_v = 1'b1; req_w = w; req_addr = addr; req_data = data;
        req_size = e_bedrock_msg_size_8; lce_id = lce;
        @(negedge clk);
        req_v = 1'b0; req_w = ~w; req_addr = ~addr; req_data = ~data; lce_id = ~lce;
        lat = 1;
        check({tag, " cmd_v"}, mem_cmd_v, 1'b1);
        held = mem_cmd;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            lat++;
        end
        if (stall > 0) begin
            check({tag, " stall cmd_v"}, mem_cmd_v, 1'b1);
            check({tag, " stall cmd stable"}, mem_cmd, held);
        end
        mem_cmd_ready = 1'b1;
        ec = exp_cmd_q.pop_front();
        check({tag, " cmd"}, mem_cmd, ec);
        @(negedge clk);
        lat++;
        mem_cmd_ready = 1'b0;
        check({tag, " cmd_v drop"}, mem_cmd_v, 1'b0);

        if (mode != 3) begin
            for (int i = 0; i < wait_n; i++) begin
                @(negedge clk);
                lat++;
            end
            rt = w ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
            if (mode == 2) rt = w ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
            mem_resp   = mk_resp(rt, (mode == 1) ? (addr ^ 40'h8) : addr, resp_data);
            mem_resp_v = 1'b1;
            #1;
            check({tag, " resp_yumi"}, mem_resp_yumi, 1'b1);
            @(negedge clk);
            lat++;
            mem_resp_v = 1'b0;
        end

        guard = 0;
        while (!rdata_v && guard < 100) begin
            @(negedge clk);
            lat++;
            guard++;
        end
        er = exp_rep_q.pop_front();
        check({tag, " rdata_v"}, rdata_v, 1'b1);
        check({tag, " rdata"}, rdata, er.data);
        check({tag, " err"}, rdata_err, er.err);
        check({tag, " latency"}, lat + 1, er.lat);
        rdata_seen = rdata;
        @(negedge clk);
        check({tag, " rdata held"}, {rdata_v, rdata}, {1'b1, rdata_seen});
        rdata_yumi = 1'b1;
        @(negedge clk);
        rdata_yumi = 1'b0;
    endtask

    initial begin
        reset = 1'b0; lce_id = '0; req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0;
        req_size = '0; mem_cmd_ready = 1'b0; mem_resp = '0; mem_resp_v = 1'b0; rdata_yumi = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset req_ready", req_ready, 1'b0);
        check("reset cmd_v", mem_cmd_v, 1'b0);
        check("reset resp_yumi", mem_resp_yumi, 1'b0);
        check("reset rdata_v", rdata_v, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset rdata", rdata, 64'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("release ready before edge", req_ready, 1'b0);
        @(negedge clk);
        check("release ready after edge", req_ready, 1'b1);

        run_txn("wr_mtimecmp", 1'b1, mtimecmp_reg_base_addr_gp, 64'h100, 4'h1, 0, 0, 0, 64'h0);
        run_txn("rd_mtime_w3", 1'b0, mtime_reg_addr_gp, 64'hdead, 4'h2, 0, 3, 0, 64'h1234);
        run_txn("rd_zero_wait", 1'b0, mtime_reg_addr_gp, 64'h0, 4'h3, 0, 0, 0, 64'hcafe_f00d_0000_0001);
        run_txn("cmd_stall", 1'b1, mtimecmp_reg_base_addr_gp + 40'h8, 64'h5555, 4'h4, 10, 12, 0, 64'h0);
        run_txn("addr_mismatch", 1'b0, mtime_reg_addr_gp, 64'h0, 4'h5, 0, 1, 1, 64'habc);
        run_txn("type_mismatch", 1'b1, mtimecmp_reg_base_addr_gp, 64'h77, 4'h6, 0, 0, 2, 64'h99);
        run_txn("resp_at_expiry", 1'b0, mtime_reg_addr_gp, 64'h0, 4'h9, 0, int'(timeout_lp) - 1, 0, 64'h1515);
        run_txn("timeout", 1'b0, mtime_reg_addr_gp, 64'h0, 4'h7, 0, 0, 3, 64'h0);

        check("drain busy", busy, 1'b1);
        check("drain not ready", req_ready, 1'b0);
        @(negedge clk);
        check("drain waits", busy, 1'b1);
        mem_resp   = mk_resp(e_bedrock_mem_uc_rd, mtime_reg_addr_gp, 64'hbad);
        mem_resp_v = 1'b1;
        #1;
        check("drain yumi", mem_resp_yumi, 1'b1);
        @(negedge clk);
        mem_resp_v = 1'b0;
        check("drain done busy", busy, 1'b0);
        check("drain done ready", req_ready, 1'b1);

        run_txn("after_drain", 1'b0, mtime_reg_addr_gp, 64'h0, 4'h8, 0, 2, 0, 64'h4242);

        mem_resp   = mk_resp(e_bedrock_mem_uc_rd, mtime_reg_addr_gp, 64'h666);
        mem_resp_v = 1'b1;
        #1;
        check("spurious yumi", mem_resp_yumi, 1'b0);
        @(negedge clk);
        check("spurious ignored", {busy, req_ready, mem_resp_yumi}, 3'b010);
        mem_resp_v = 1'b0;

        run_txn("after_spurious", 1'b1, mtimecmp_reg_base_addr_gp, 64'h0123_4567_89ab_cdef, 4'ha, 0, 1, 0, 64'h0);

        req_v = 1'b1; req_w = 1'b0; req_addr = mtime_reg_addr_gp; req_size = e_bedrock_msg_size_8; lce_id = 4'hb;
        @(negedge clk);
        req_v = 1'b0;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        check("mid wait busy", busy, 1'b1);
        #2;
        reset      = 1'b1;
        mem_resp   = mk_resp(e_bedrock_mem_uc_rd, mtime_reg_addr_gp, 64'h777);
        mem_resp_v = 1'b1;
        #1;
        check("async reset outputs",
              {req_ready, mem_cmd_v, mem_resp_yumi, rdata_v, busy, rdata_err, rdata},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        @(negedge clk);
        check("held reset ready", req_ready, 1'b0);
        mem_resp_v = 1'b0;
        reset      = 1'b0;
        #1;
        check("mid release ready before edge", req_ready, 1'b0);
        @(negedge clk);
        check("mid release ready", req_ready, 1'b1);
        check("no replay / reply", {mem_cmd_v, rdata_v, busy}, 3'b000);

        run_txn("after_reset", 1'b1, mtimecmp_reg_base_addr_gp + 40'h10, 64'h55aa, 4'hc, 2, 0, 0, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
